// File: rtl/shared_dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between two MIPS cores.
// Define ARB_LOCK_EN to add C0_Lock/C1_Lock for owner-held atomic sequences.
module shared_dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              C0_Req,
  input  logic              C0_Write,
  input  logic [ADDR_W-1:0] C0_Addr,
  input  logic [DATA_W-1:0] C0_WData,
  input  logic              C1_Req,
  input  logic              C1_Write,
  input  logic [ADDR_W-1:0] C1_Addr,
  input  logic [DATA_W-1:0] C1_WData,
`ifdef ARB_LOCK_EN
  input  logic              C0_Lock,
  input  logic              C1_Lock,
`endif
  output logic              C0_Ack,
  output logic [DATA_W-1:0] C0_RData,
  output logic              C0_Stall,
  output logic              C1_Ack,
  output logic [DATA_W-1:0] C1_RData,
  output logic              C1_Stall,
  output logic [ADDR_W-1:0] M_Addr,
  output logic [DATA_W-1:0] M_WData,
  output logic              M_MemWrite,
  output logic              M_MemRead,
  input  logic [DATA_W-1:0] M_RData,
  output logic              Owner,
  output logic              Busy
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q;
  logic              owner_q, write_q, first_q, ack0_q, ack1_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  logic              grant_d, win_d;

  // Tie goes to the core that did not win last; a single requester always wins.
  always_comb begin
    grant_d = C0_Req | C1_Req;
    win_d   = (C0_Req & C1_Req) ? ~owner_q : C1_Req;
`ifdef ARB_LOCK_EN
    if (owner_q ? C1_Lock : C0_Lock) begin
      grant_d = owner_q ? C1_Req : C0_Req;
      win_d   = owner_q;
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b1;
      write_q  <= 1'b0;
      first_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q <= win_d;
            addr_q  <= win_d ? C1_Addr  : C0_Addr;
            wdata_q <= win_d ? C1_WData : C0_WData;
            write_q <= win_d ? C1_Write : C0_Write;
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            first_q <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          first_q <= 1'b0;
          if (cnt_q == '0) begin
            if (!write_q) begin
              if (owner_q) rdata1_q <= M_RData;
              else         rdata0_q <= M_RData;
            end
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory bus is quiet outside ACCESS; the store strobe fires once per transaction.
  assign M_Addr     = (state_q == ACCESS) ? addr_q  : '0;
  assign M_WData    = (state_q == ACCESS) ? wdata_q : '0;
  assign M_MemWrite = (state_q == ACCESS) & write_q & first_q;
  assign M_MemRead  = (state_q == ACCESS) & ~write_q;

  assign C0_Ack   = ack0_q;
  assign C1_Ack   = ack1_q;
  assign C0_RData = rdata0_q;
  assign C1_RData = rdata1_q;
  assign C0_Stall = C0_Req & ~ack0_q;
  assign C1_Stall = C1_Req & ~ack1_q;
  assign Owner    = owner_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Directed bench for shared_dmem_arbiter: three instances (MEM_LAT 1..3) share stimulus,
// each with its own word memory; a given test checks only one instance.
module tb_shared_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          c0_req, c1_req, c0_wr, c1_wr, c0_lock, c1_lock;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wd, c1_wd;

  logic          ack0 [1:3];
  logic          ack1 [1:3];
  logic          stl0 [1:3];
  logic          stl1 [1:3];
  logic          mw   [1:3];
  logic          mr   [1:3];
  logic          own  [1:3];
  logic          bsy  [1:3];
  logic [DW-1:0] rd0  [1:3];
  logic [DW-1:0] rd1  [1:3];
  logic [AW-1:0] maddr[1:3];
  logic [DW-1:0] mwd  [1:3];
  logic [DW-1:0] mrd  [1:3];

  logic          pre_we;
  int            pre_sel;
  logic [7:0]    pre_a;
  logic [31:0]   pre_d;

  int checks = 0;
  int errors = 0;
  int ev_core[$];
  int ev_cyc[$];

  always #5 Clk = ~Clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    logic [DW-1:0] mem [0:255];
    assign mrd[g] = mem[maddr[g][7:0]];
    always @(posedge Clk) begin
      if (pre_we && pre_sel == g) mem[pre_a] <= pre_d;
      else if (mw[g])             mem[maddr[g][7:0]] <= mwd[g];
    end
    shared_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g)) u_dut (
      .Clk(Clk), .Reset(Reset),
      .C0_Req(c0_req), .C0_Write(c0_wr), .C0_Addr(c0_addr), .C0_WData(c0_wd),
      .C1_Req(c1_req), .C1_Write(c1_wr), .C1_Addr(c1_addr), .C1_WData(c1_wd),
`ifdef ARB_LOCK_EN
      .C0_Lock(c0_lock), .C1_Lock(c1_lock),
`endif
      .C0_Ack(ack0[g]), .C0_RData(rd0[g]), .C0_Stall(stl0[g]),
      .C1_Ack(ack1[g]), .C1_RData(rd1[g]), .C1_Stall(stl1[g]),
      .M_Addr(maddr[g]), .M_WData(mwd[g]), .M_MemWrite(mw[g]), .M_MemRead(mr[g]),
      .M_RData(mrd[g]), .Owner(own[g]), .Busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int evc(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1;
  endfunction

  function automatic int evk(input int i);
    return (i < ev_core.size()) ? ev_core[i] : -1;
  endfunction

  task automatic nxt();
    @(posedge Clk); #1;
  endtask

  task automatic idle_inputs();
    c0_req = 0; c1_req = 0; c0_wr = 0; c1_wr = 0; c0_lock = 0; c1_lock = 0;
    c0_addr = '0; c1_addr = '0; c0_wd = '0; c1_wd = '0;
  endtask

  // Leaves the caller at the start of cycle 0 with reset released.
  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    repeat (2) nxt();
    Reset = 0;
  endtask

  task automatic pre_write(input int sel, input logic [7:0] a, input logic [31:0] d);
    pre_we = 1; pre_sel = sel; pre_a = a; pre_d = d;
    nxt();
    pre_we = 0;
  endtask

  // Cycle-by-cycle requester model; records every Ack as (core, cycle).
  task automatic run(input int L, input int ncyc, input bit sustain, input int unlock_at);
    bit drop0, drop1;
    ev_core.delete(); ev_cyc.delete();
    drop0 = 0; drop1 = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == unlock_at) c0_lock = 0;
      if (drop0) c0_req = 0;
      if (drop1) c1_req = 0;
      drop0 = 0; drop1 = 0;
      @(negedge Clk);
      if (ack0[L]) begin ev_core.push_back(0); ev_cyc.push_back(k); drop0 = !sustain; end
      if (ack1[L]) begin ev_core.push_back(1); ev_cyc.push_back(k); drop1 = !sustain; end
      nxt();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int nw, a1;
    pre_we = 0; pre_sel = 0; pre_a = '0; pre_d = '0;
    idle_inputs();
    Reset = 1;
    pre_write(1, 8'h10, 32'hDEADBEEF);
    pre_write(3, 8'h30, 32'hCAFE0123);
    @(negedge Clk);
    chk("rst_owner", own[1], 1);
    chk("rst_busy",  bsy[1], 0);
    chk("rst_ack0",  ack0[1], 0);
    chk("rst_ack1",  ack1[1], 0);
    chk("rst_rd0",   rd0[1], 0);
    chk("rst_rd1",   rd1[1], 0);
    chk("rst_maddr", maddr[1], 0);
    chk("rst_mw",    mw[1], 0);
    chk("rst_mr",    mr[1], 0);

    // Core0 load, MEM_LAT=1
    nxt(); Reset = 0;
    c0_req = 1; c0_wr = 0; c0_addr = 32'h10;
    @(negedge Clk);
    chk("ld_c0_stall_same_cycle", stl0[1], 1);
    chk("ld_c0_busy_c0", bsy[1], 0);
    nxt(); c0_addr = 32'h55;
    @(negedge Clk);
    chk("ld_c1_mread", mr[1], 1);
    chk("ld_c1_maddr_latched", maddr[1], 32'h10);
    chk("ld_c1_busy", bsy[1], 1);
    chk("ld_c1_no_ack", ack0[1], 0);
    nxt();
    @(negedge Clk);
    chk("ld_c2_ack", ack0[1], 1);
    chk("ld_c2_rdata", rd0[1], 32'hDEADBEEF);
    chk("ld_c2_stall", stl0[1], 0);
    chk("ld_c2_mread", mr[1], 0);
    nxt(); c0_req = 0;
    @(negedge Clk);
    chk("ld_c3_ack_gone", ack0[1], 0);
    chk("ld_c3_rdata_held", rd0[1], 32'hDEADBEEF);
    chk("ld_c3_busy", bsy[1], 0);

    // Tie after reset, MEM_LAT=1
    do_reset();
    c0_req = 1; c1_req = 1;
    run(1, 8, 0, -1);
    chk("tie_nev", ev_cyc.size(), 2);
    chk("tie_first_core", evk(0), 0);
    chk("tie_first_cyc", evc(0), 2);
    chk("tie_second_core", evk(1), 1);
    chk("tie_second_cyc", evc(1), 5);
    chk("tie_owner", own[1], 1);

    // Sustained contention, MEM_LAT=2
    do_reset();
    c0_req = 1; c1_req = 1;
    run(2, 12, 1, -1);
    chk("sus_nev", ev_cyc.size(), 3);
    chk("sus_g0", evk(0), 0);
    chk("sus_g1", evk(1), 1);
    chk("sus_g2", evk(2), 0);
    chk("sus_t0", evc(0), 3);
    chk("sus_t1", evc(1), 7);
    chk("sus_t2", evc(2), 11);

    // Core1 store then Core0 load-back, MEM_LAT=3
    do_reset();
    c1_req = 1; c1_wr = 1; c1_addr = 32'h20; c1_wd = 32'h12345678;
    nw = 0; a1 = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (mw[3]) nw++;
      if (ack1[3]) a1 = k;
      if (k == 1) begin
        chk("st_maddr", maddr[3], 32'h20);
        chk("st_mwdata", mwd[3], 32'h12345678);
      end
      nxt();
      c1_wd = 32'hFFFFFFFF;
      if (a1 >= 0) c1_req = 0;
    end
    chk("st_mwrite_cycles", nw, 1);
    chk("st_ack_cyc", a1, 4);
    chk("st_rd1_untouched", rd1[3], 0);
    c0_req = 1; c0_wr = 0; c0_addr = 32'h20;
    run(3, 8, 0, -1);
    chk("lb_nev", ev_cyc.size(), 1);
    chk("lb_core", evk(0), 0);
    chk("lb_cyc", evc(0), 4);
    chk("lb_rdata", rd0[3], 32'h12345678);

    // Reset during second ACCESS cycle of a load, MEM_LAT=3
    do_reset();
    c0_req = 1; c0_wr = 0; c0_addr = 32'h30;
    nxt();
    @(negedge Clk);
    chk("rm_first_access", mr[3], 1);
    nxt(); Reset = 1;
    @(negedge Clk);
    chk("rm_busy", bsy[3], 0);
    chk("rm_ack", ack0[3], 0);
    chk("rm_mread", mr[3], 0);
    chk("rm_rd0", rd0[3], 0);
    nxt(); Reset = 0;
    run(3, 7, 0, -1);
    chk("rm_nev", ev_cyc.size(), 1);
    chk("rm_cyc", evc(0), 4);
    chk("rm_rdata", rd0[3], 32'hCAFE0123);

`ifdef ARB_LOCK_EN
    // Core0 holds the lock for three transactions, then releases
    do_reset();
    c0_lock = 1; c0_req = 1; c1_req = 1;
    run(1, 13, 1, 9);
    chk("lk_nev", ev_cyc.size(), 4);
    chk("lk_g0", evk(0), 0);
    chk("lk_g1", evk(1), 0);
    chk("lk_g2", evk(2), 0);
    chk("lk_g3", evk(3), 1);
    chk("lk_t3", evc(3), 11);
`endif

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shared_dmem_arbiter.md
# shared_dmem_arbiter

Two-port arbiter that shares one data memory between Core0 and Core1 of the dual-core MIPS system. Each core's MEM stage issues a single-word load/store request. The arbiter grants one core at a time using round-robin, sequences the memory for a fixed access latency, and returns read data with a one-cycle acknowledge. While a core's request is outstanding, the arbiter asserts that core's stall output, which freezes the core's pipeline (PC, IF/ID, ID/EX, EX/MEM enables).

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory access cycles per transaction; legal range 1..4

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- C0_Req, C1_Req  in  1  request; held high until the matching Ack
- C0_Write, C1_Write  in  1  1 = store, 0 = load
- C0_Addr, C1_Addr  in  ADDR_W  word address
- C0_WData, C1_WData  in  DATA_W  store data
- C0_Ack, C1_Ack  out  1  one-cycle completion pulse
- C0_RData, C1_RData  out  DATA_W  load data, valid while Ack is high and held until the next completion for that core
- C0_Stall, C1_Stall  out  1  equals Req & ~Ack
- M_Addr  out  ADDR_W  memory address
- M_WData  out  DATA_W  memory write data
- M_MemWrite, M_MemRead  out  1  memory controls
- M_RData  in  DATA_W  memory read data, combinational from M_Addr
- Owner  out  1  last-granted core
- Busy  out  1  high when the state is not IDLE
- C0_Lock, C1_Lock  in  1  present only when ARB_LOCK_EN is defined

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If no Req is high, stay in IDLE.
  - If exactly one Req is high, grant that core.
  - If both are high, grant the core that is not Owner.
  - On grant: latch Addr, WData and Write into internal registers, set Owner to the winner, load a counter with MEM_LAT-1, and go to ACCESS.
- **ACCESS**
  - M_Addr and M_WData are driven from the latched registers.
  - M_MemWrite is high only in the first ACCESS cycle of a store.
  - M_MemRead is high in every ACCESS cycle of a load.
  - The counter decrements each cycle. When it reaches 0 and the transaction is a load, capture M_RData into the winner's RData register at that edge. Then go to DONE.
- **DONE**
  - The winner's Ack is high for this single cycle.
  - All Req inputs are ignored in this cycle.
  - Next state is IDLE.
- Outside ACCESS, all memory outputs are 0.
- Inputs are latched at grant; a requester changing Addr/WData after grant has no effect on the transaction.
- A Req that drops before Ack (protocol violation) does not abort the transaction; the Ack still issues.

## Timing
- Reset values: state IDLE; Owner = 1 (so Core0 wins the first tie); Busy 0; both Ack 0; both RData 0; counter 0; all M_* outputs 0.
- Transaction timeline for a request sampled high at edge N:
  - ACCESS occupies cycles N+1 .. N+MEM_LAT.
  - Ack is high in cycle N+MEM_LAT+1.
  - The earliest next grant occurs at edge N+MEM_LAT+2.
- Throughput: one transaction per MEM_LAT+2 cycles.
- Worst-case wait for a continuously requesting core: one full transaction of the other core (fairness bound).
- Stall is combinational from Req and Ack, so a core stalls in the same cycle it raises Req.
- Simultaneous requests in IDLE: the non-Owner core wins; the loser stays stalled and is granted at the next IDLE.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and no Ack is issued.
  - A store whose first ACCESS edge has already occurred remains written.

## Configuration
- Macro: ARB_LOCK_EN.
- Defined:
  - The C0_Lock and C1_Lock ports exist.
  - In IDLE, if the Owner core's Lock is high, only that core may be granted, even on a tie. This supports atomic read-modify-write sequences.
  - The lock releases when the Owner's Lock is low in IDLE.
- Undefined:
  - The Lock ports are absent.
  - Arbitration is pure round-robin as described in Operation.

## Test plan
- **Reset, then Core0 load:** Reset; C0_Req=1, C0_Write=0, C0_Addr=0x10, memory[0x10]=0xDEADBEEF, MEM_LAT=1 -> M_MemRead high in cycle 1, C0_Ack high in cycle 2, C0_RData=0xDEADBEEF, C0_Stall low in cycle 2.
- **Tie after reset:** C0_Req and C1_Req rise together -> Core0 is granted first. Core1 Ack arrives 3 cycles after Core0 Ack (MEM_LAT=1). Owner ends at 1.
- **Sustained contention:** both Req held high for 12 cycles with MEM_LAT=2 -> grants alternate 0,1,0; every Ack is spaced 4 cycles apart.
- **Store:** C1 stores 0x12345678 to 0x20 with MEM_LAT=3 -> M_MemWrite is high in exactly one cycle. A following C0 load of 0x20 returns 0x12345678.
- **Reset mid-transaction:** assert Reset during the second ACCESS cycle of a load (MEM_LAT=3) -> no Ack, Busy=0, and the next request completes normally.
- **Lock (ARB_LOCK_EN defined):** C0_Lock=1 with both Req high for three transactions -> all three grants go to Core0. Dropping C0_Lock -> the next grant goes to Core1.
